fetch_stage: RTL

IF stage of the 5-stage MIPS pipeline, directly downstream of the next-PC logic. It holds the architectural fetch PC (PC_F) and loads the next-PC value every cycle. It checks the fetch address for AdEL, marks delay-slot instructions, and drives the IF/ID pipeline register that feeds decode. Stall, exception-entry flush and eret redirect are all resolved here with fixed priority.

---
 rtl/fetch_stage.sv | 63 ++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: fetch PC, AdEL check and IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic [31:0] N_PC,
    input  logic        ActivateCP0,
    input  logic        CoolCP0,
    input  logic        Is_Jump_D,
    input  logic [31:0] Instr_IM,
    output logic [31:0] PC_F,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC8_D,
    output logic [4:0]  ExcCode_D,
    output logic        BD_D
);

    logic        adel_f;
    logic [31:0] instr_f;
    logic [4:0]  exc_f;
    logic        redirect;

    assign redirect = ActivateCP0 | CoolCP0;

    // An illegal fetch still flows to D as a nop so CP0 sees its PC and BD flag.
    always_comb begin
        adel_f  = (PC_F[1:0] != 2'b00) || (PC_F < IM_LO) || (PC_F > IM_HI);
        instr_f = adel_f ? 32'h0 : Instr_IM;
        exc_f   = adel_f ? EXC_ADEL : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            PC_F <= RESET_PC;
        end else if (redirect || !Stall) begin
            PC_F <= N_PC;
        end
    end

    // eret has no delay slot, so a redirect discards whatever is in F.
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            Instr_D   <= 32'h0;
            PC_D      <= 32'h0;
            PC8_D     <= 32'h0;
            ExcCode_D <= 5'd0;
            BD_D      <= 1'b0;
        end else if (!Stall) begin
            Instr_D   <= instr_f;
            PC_D      <= PC_F;
            PC8_D     <= PC_F + 32'd8;
            ExcCode_D <= exc_f;
            BD_D      <= Is_Jump_D;
        end
    end

endmodule
